// File: rtl/axibus2rambus.sv
// Single-burst AXI4 read master: fetches I_len beats from I_base_addr and writes them to the ibuf RAM from address 0.
// Define AXIBUS2RAMBUS_RESP_CHK_EN to add a sticky O_err for bad rresp or misplaced rlast.
module axibus2rambus #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_LEN_WIDTH  = 8,
  parameter int C_M_AXI_SIZE_WIDTH = 3,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 128,
  parameter int C_RAM_ADDR_WIDTH   = 10,
  parameter int C_RAM_DATA_WIDTH   = 128
) (
  input  logic                          I_clk,
  input  logic                          I_rst_n,
  input  logic                          I_ap_start,
  output logic                          O_ap_done,
  output logic                          O_ap_idle,
  output logic                          O_ap_ready,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
  input  logic [C_RAM_ADDR_WIDTH-1:0]   I_len,
  output logic [C_M_AXI_ID_WIDTH-1:0]   O_maxi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] O_maxi_araddr,
  output logic [C_M_AXI_LEN_WIDTH-1:0]  O_maxi_arlen,
  output logic [C_M_AXI_SIZE_WIDTH-1:0] O_maxi_arsize,
  output logic [1:0]                    O_maxi_arburst,
  output logic                          O_maxi_arvalid,
  input  logic                          I_maxi_arready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] I_maxi_rdata,
  input  logic [1:0]                    I_maxi_rresp,
  input  logic                          I_maxi_rlast,
  input  logic                          I_maxi_rvalid,
  output logic                          O_maxi_rready,
  output logic [C_RAM_ADDR_WIDTH-1:0]   O_waddr,
  output logic                          O_wr,
  output logic [C_RAM_DATA_WIDTH-1:0]   O_wdata
`ifdef AXIBUS2RAMBUS_RESP_CHK_EN
  ,output logic                         O_err
`endif
);

  typedef enum logic [2:0] {IDLE, AR, RD, FIN, DONE} state_t;

  localparam logic [C_RAM_ADDR_WIDTH-1:0] ONE = C_RAM_ADDR_WIDTH'(1);

  state_t                      state, state_next;
  logic [C_RAM_ADDR_WIDTH-1:0] s_len;
  logic [C_RAM_ADDR_WIDTH-1:0] beat_cnt;
  logic                        beat_ok;
  logic                        last_beat;

  assign O_maxi_arid    = '0;
  assign O_maxi_arburst = 2'b01;
  assign O_maxi_arsize  = C_M_AXI_SIZE_WIDTH'($clog2(C_M_AXI_DATA_WIDTH / 8));

  assign beat_ok   = (state == RD) && I_maxi_rvalid && O_maxi_rready;
  // Termination follows the beat count only; rlast is never trusted for it.
  assign last_beat = (beat_cnt == s_len - ONE);

`ifndef AXIBUS2RAMBUS_RESP_CHK_EN
  logic unused_resp;
  assign unused_resp = ^{I_maxi_rresp, I_maxi_rlast};
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (I_ap_start) state_next = (I_len == '0) ? FIN : AR;
      AR:   if (I_maxi_arready) state_next = RD;
      RD:   if (beat_ok && last_beat) state_next = FIN;
      FIN:  state_next = DONE;
      DONE: if (!I_ap_start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_ap_done      <= 1'b0;
      O_ap_ready     <= 1'b0;
      O_ap_idle      <= 1'b1;
      O_maxi_araddr  <= '0;
      O_maxi_arlen   <= '0;
      O_maxi_arvalid <= 1'b0;
      O_maxi_rready  <= 1'b0;
      O_wr           <= 1'b0;
      O_waddr        <= '0;
      O_wdata        <= '0;
      s_len          <= '0;
      beat_cnt       <= '0;
`ifdef AXIBUS2RAMBUS_RESP_CHK_EN
      O_err          <= 1'b0;
`endif
    end else begin
      O_wr       <= 1'b0;
      O_ap_done  <= 1'b0;
      O_ap_ready <= 1'b0;
      case (state)
        IDLE: if (I_ap_start) begin
          O_maxi_araddr  <= I_base_addr;
          O_maxi_arlen   <= C_M_AXI_LEN_WIDTH'(I_len - ONE);
          O_maxi_arvalid <= (I_len != '0);
          s_len          <= I_len;
          beat_cnt       <= '0;
          O_ap_idle      <= 1'b0;
`ifdef AXIBUS2RAMBUS_RESP_CHK_EN
          O_err          <= 1'b0;
`endif
        end
        AR: if (I_maxi_arready) begin
          O_maxi_arvalid <= 1'b0;
          O_maxi_rready  <= 1'b1;
        end
        RD: if (beat_ok) begin
          O_wr     <= 1'b1;
          O_waddr  <= beat_cnt;
          O_wdata  <= C_RAM_DATA_WIDTH'(I_maxi_rdata);
          beat_cnt <= beat_cnt + ONE;
          if (last_beat) O_maxi_rready <= 1'b0;
`ifdef AXIBUS2RAMBUS_RESP_CHK_EN
          if ((I_maxi_rresp != 2'b00) || (I_maxi_rlast != last_beat)) O_err <= 1'b1;
`endif
        end
        FIN: begin
          O_ap_done  <= 1'b1;
          O_ap_ready <= 1'b1;
        end
        DONE: if (!I_ap_start) O_ap_idle <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axibus2rambus.sv
// Directed bench for axibus2rambus: acts as the AXI read slave and logs RAM writes on the falling edge.
`timescale 1ns/1ps
module tb_axibus2rambus;
  localparam int AW = 32, DW = 128, RW = 10, LW = 8;

  logic          I_clk = 1'b0, I_rst_n = 1'b0, I_ap_start = 1'b0;
  logic          O_ap_done, O_ap_idle, O_ap_ready;
  logic [AW-1:0] I_base_addr = '0;
  logic [RW-1:0] I_len = '0;
  logic [0:0]    O_maxi_arid;
  logic [AW-1:0] O_maxi_araddr;
  logic [LW-1:0] O_maxi_arlen;
  logic [2:0]    O_maxi_arsize;
  logic [1:0]    O_maxi_arburst;
  logic          O_maxi_arvalid, O_maxi_rready, O_wr;
  logic          I_maxi_arready = 1'b0, I_maxi_rlast = 1'b0, I_maxi_rvalid = 1'b0;
  logic [DW-1:0] I_maxi_rdata = '0;
  logic [1:0]    I_maxi_rresp = '0;
  logic [RW-1:0] O_waddr;
  logic [DW-1:0] O_wdata;
`ifdef AXIBUS2RAMBUS_RESP_CHK_EN
  logic          O_err;
`endif

  always #5 I_clk = ~I_clk;

  axibus2rambus dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_ap_start(I_ap_start),
    .O_ap_done(O_ap_done), .O_ap_idle(O_ap_idle), .O_ap_ready(O_ap_ready),
    .I_base_addr(I_base_addr), .I_len(I_len),
    .O_maxi_arid(O_maxi_arid), .O_maxi_araddr(O_maxi_araddr), .O_maxi_arlen(O_maxi_arlen),
    .O_maxi_arsize(O_maxi_arsize), .O_maxi_arburst(O_maxi_arburst),
    .O_maxi_arvalid(O_maxi_arvalid), .I_maxi_arready(I_maxi_arready),
    .I_maxi_rdata(I_maxi_rdata), .I_maxi_rresp(I_maxi_rresp), .I_maxi_rlast(I_maxi_rlast),
    .I_maxi_rvalid(I_maxi_rvalid), .O_maxi_rready(O_maxi_rready),
    .O_waddr(O_waddr), .O_wr(O_wr), .O_wdata(O_wdata)
`ifdef AXIBUS2RAMBUS_RESP_CHK_EN
    ,.O_err(O_err)
`endif
  );

  int nvec = 0, nerr = 0, cyc = 0;
  always @(posedge I_clk) cyc <= cyc + 1;

  // Falling-edge monitor: RAM writes, beat handshakes, done pulses and AR stability.
  logic [RW-1:0] wa [0:127];
  logic [DW-1:0] wd [0:127];
  int            wc [0:127];
  int            n_wr = 0, hs_cyc = 0, done_cyc = 0, n_ar = 0, ar_unstable = 0;
  logic          prev_av = 1'b0;
  logic [AW-1:0] prev_aa = '0;
  logic [LW-1:0] prev_al = '0;
  always @(negedge I_clk) begin
    if (O_wr) begin
      wa[n_wr % 128] = O_waddr;
      wd[n_wr % 128] = O_wdata;
      wc[n_wr % 128] = cyc;
      n_wr++;
    end
    if (I_maxi_rvalid && O_maxi_rready) hs_cyc = cyc;
    if (O_ap_done) done_cyc = cyc;
    if (O_maxi_arvalid) n_ar++;
    if (O_maxi_arvalid && prev_av && (O_maxi_araddr != prev_aa || O_maxi_arlen != prev_al))
      ar_unstable++;
    prev_av = O_maxi_arvalid;
    prev_aa = O_maxi_araddr;
    prev_al = O_maxi_arlen;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge I_clk); #1;
  endtask

  task automatic settle();
    @(negedge I_clk); #1;
  endtask

  task automatic go(input logic [AW-1:0] base, input logic [RW-1:0] len);
    I_base_addr = base;
    I_len       = len;
    I_ap_start  = 1'b1;
  endtask

  task automatic ar_phase(input int dly);
    for (int i = 0; i < dly; i++) tick();
    I_maxi_arready = 1'b1;
    tick();
    I_maxi_arready = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic last, input logic [1:0] resp);
    I_maxi_rvalid = 1'b1;
    I_maxi_rdata  = d;
    I_maxi_rlast  = last;
    I_maxi_rresp  = resp;
    tick();
    I_maxi_rvalid = 1'b0;
    I_maxi_rlast  = 1'b0;
    I_maxi_rresp  = 2'b00;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!O_ap_done && n < 20) begin
      tick();
      n++;
    end
    chk(tag, 128'(O_ap_done), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int w0, a0;

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_idle",    128'(O_ap_idle),      128'd1);
    chk("rst_arvalid", 128'(O_maxi_arvalid), 128'd0);
    chk("rst_rready",  128'(O_maxi_rready),  128'd0);
    chk("rst_wr",      128'(O_wr),           128'd0);
    chk("rst_waddr",   128'(O_waddr),        128'd0);
    chk("rst_done",    128'(O_ap_done),      128'd0);
    chk("rst_ready",   128'(O_ap_ready),     128'd0);
    I_rst_n = 1'b1;
    tick();

    // Basic burst: len 4, data 1..4
    w0 = n_wr;
    go(32'h1000_0000, 10'd4);
    tick();
    chk("t1_arvalid", 128'(O_maxi_arvalid), 128'd1);
    chk("t1_araddr",  128'(O_maxi_araddr),  128'h1000_0000);
    chk("t1_arlen",   128'(O_maxi_arlen),   128'd3);
    chk("t1_arsize",  128'(O_maxi_arsize),  128'd4);
    chk("t1_arburst", 128'(O_maxi_arburst), 128'd1);
    chk("t1_busy",    128'(O_ap_idle),      128'd0);
    ar_phase(0);
    chk("t1_rready",  128'(O_maxi_rready),  128'd1);
    chk("t1_ar_drop", 128'(O_maxi_arvalid), 128'd0);
    for (int i = 0; i < 4; i++) beat(DW'(i + 1), (i == 3), 2'b00);
    wait_done("t1_done");
    chk("t1_ap_ready", 128'(O_ap_ready), 128'd1);
    settle();
    chk("t1_nwr", 128'(n_wr - w0), 128'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_waddr", 128'(wa[(w0 + i) % 128]), 128'(i));
      chk("t1_wdata", wd[(w0 + i) % 128], 128'(i + 1));
    end
    chk("t1_lat", 128'(done_cyc - hs_cyc), 128'd2);
    tick();
    chk("t1_pulse",    128'(O_ap_done), 128'd0);
    chk("t1_hold",     128'(O_ap_idle), 128'd0);
    I_ap_start = 1'b0;
    tick();
    chk("t1_idle",     128'(O_ap_idle), 128'd1);

    // Backpressure: arready after 5 cycles, rvalid 1,0,1,0,1
    w0 = n_wr;
    a0 = ar_unstable;
    go(32'h2000_0040, 10'd3);
    tick();
    for (int i = 0; i < 5; i++) tick();
    chk("t2_arvalid", 128'(O_maxi_arvalid), 128'd1);
    chk("t2_araddr",  128'(O_maxi_araddr),  128'h2000_0040);
    chk("t2_arlen",   128'(O_maxi_arlen),   128'd2);
    chk("t2_stable",  128'(ar_unstable - a0), 128'd0);
    ar_phase(0);
    beat(128'hA0, 1'b0, 2'b00);
    tick();
    beat(128'hA1, 1'b0, 2'b00);
    tick();
    beat(128'hA2, 1'b1, 2'b00);
    wait_done("t2_done");
    settle();
    chk("t2_nwr", 128'(n_wr - w0), 128'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2_waddr", 128'(wa[(w0 + i) % 128]), 128'(i));
      chk("t2_wdata", wd[(w0 + i) % 128], 128'(32'hA0 + i));
    end
    chk("t2_gap0", 128'(wc[(w0 + 1) % 128] - wc[w0 % 128]), 128'd2);
    chk("t2_gap1", 128'(wc[(w0 + 2) % 128] - wc[(w0 + 1) % 128]), 128'd2);
    I_ap_start = 1'b0;
    tick();
    chk("t2_idle", 128'(O_ap_idle), 128'd1);

    // Zero length
    w0 = n_wr;
    a0 = n_ar;
    go(32'h3000_0000, 10'd0);
    tick();
    chk("t3_done_early", 128'(O_ap_done), 128'd0);
    chk("t3_busy",       128'(O_ap_idle), 128'd0);
    tick();
    chk("t3_done",  128'(O_ap_done),  128'd1);
    chk("t3_ready", 128'(O_ap_ready), 128'd1);
    I_ap_start = 1'b0;
    tick();
    chk("t3_idle", 128'(O_ap_idle), 128'd1);
    settle();
    chk("t3_no_ar", 128'(n_ar - a0), 128'd0);
    chk("t3_no_wr", 128'(n_wr - w0), 128'd0);

    // Reset after beat 2 of a len 8 burst
    go(32'h4000_0000, 10'd8);
    tick();
    ar_phase(0);
    beat(128'hB0, 1'b0, 2'b00);
    beat(128'hB1, 1'b0, 2'b00);
    chk("t4_pre_wr", 128'(O_wr), 128'd1);
    I_rst_n    = 1'b0;
    I_ap_start = 1'b0;
    #1;
    chk("t4_rready", 128'(O_maxi_rready),  128'd0);
    chk("t4_arvld",  128'(O_maxi_arvalid), 128'd0);
    chk("t4_wr",     128'(O_wr),           128'd0);
    chk("t4_waddr",  128'(O_waddr),        128'd0);
    chk("t4_done",   128'(O_ap_done),      128'd0);
    chk("t4_idle",   128'(O_ap_idle),      128'd1);
    #2 I_rst_n = 1'b1;
    tick();
    w0 = n_wr;
    go(32'h4100_0000, 10'd2);
    tick();
    chk("t4b_araddr", 128'(O_maxi_araddr), 128'h4100_0000);
    chk("t4b_arlen",  128'(O_maxi_arlen),  128'd1);
    ar_phase(0);
    beat(128'hC0, 1'b0, 2'b00);
    beat(128'hC1, 1'b1, 2'b00);
    wait_done("t4b_done");
    settle();
    chk("t4b_nwr", 128'(n_wr - w0), 128'd2);
    for (int i = 0; i < 2; i++) begin
      chk("t4b_waddr", 128'(wa[(w0 + i) % 128]), 128'(i));
      chk("t4b_wdata", wd[(w0 + i) % 128], 128'(32'hC0 + i));
    end
    I_ap_start = 1'b0;
    tick();

    // Start drops mid-burst, len 6
    w0 = n_wr;
    go(32'h5000_0000, 10'd6);
    tick();
    ar_phase(2);
    beat(128'hD0, 1'b0, 2'b00);
    beat(128'hD1, 1'b0, 2'b00);
    I_ap_start = 1'b0;
    for (int i = 2; i < 6; i++) beat(128'(32'hD0 + i), (i == 5), 2'b00);
    wait_done("t5_done");
    chk("t5_ready", 128'(O_ap_ready), 128'd1);
    tick();
    chk("t5_idle",  128'(O_ap_idle), 128'd1);
    chk("t5_pulse", 128'(O_ap_done), 128'd0);
    settle();
    chk("t5_nwr",   128'(n_wr - w0), 128'd6);
    chk("t5_waddr", 128'(wa[(w0 + 5) % 128]), 128'd5);
    chk("t5_wdata", wd[(w0 + 5) % 128], 128'hD5);

`ifdef AXIBUS2RAMBUS_RESP_CHK_EN
    // Bad rresp on beat 2, early rlast on beat 3
    w0 = n_wr;
    go(32'h6000_0000, 10'd4);
    tick();
    ar_phase(0);
    beat(128'hE0, 1'b0, 2'b00);
    beat(128'hE1, 1'b0, 2'b10);
    beat(128'hE2, 1'b1, 2'b00);
    beat(128'hE3, 1'b0, 2'b00);
    wait_done("t6_done");
    chk("t6_err", 128'(O_err), 128'd1);
    settle();
    chk("t6_nwr", 128'(n_wr - w0), 128'd4);
    I_ap_start = 1'b0;
    tick();
    go(32'h6100_0000, 10'd4);
    tick();
    chk("t6_err_clr", 128'(O_err), 128'd0);
    ar_phase(0);
    for (int i = 0; i < 4; i++) beat(128'(32'hF0 + i), (i == 3), 2'b00);
    wait_done("t6b_done");
    chk("t6b_err", 128'(O_err), 128'd0);
    I_ap_start = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
